axi_mm_patchkr_top: RTL and testbench
=====================================

# axi_mm_patchkr_top

Receive-side pattern checker for the AXI-MM full examples: it is the consuming end of the AXI-MM pattern generator's valid/ready data stream. It buffers the generator's expected-data words in an internal expected FIFO and accepts received beats only when an expected word is available. Each accepted beat is compared against the head of the expected FIFO, and the block counts beats and mismatches. At the end of a run it reports a done/pass verdict to the example's top-level status logic.

## Interface
Parameters:
- DATA_WIDTH, 128, width of expected and received data words
- EXP_DEPTH, 16, expected-FIFO depth in words (power of 2, ≥4)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- exp_din  in  DATA_WIDTH  expected word from pattern generator
- exp_wr  in  1  push exp_din into expected FIFO
- chkr_fifo_full  out  1  expected FIFO full (back-pressure to generator)
- rx_data  in  DATA_WIDTH  received beat data
- rx_valid  in  1  received beat valid
- rx_ready  out  1  checker accepts beat this cycle
- chk_start  in  1  one-cycle pulse: start a run
- chk_stop  in  1  one-cycle pulse: end a continuous run
- chk_cnt  in  8  beats per run; 0 = continuous until chk_stop
- beat_cnt  out  16  beats compared this run
- err_cnt  out  16  mismatching beats this run, saturates at 16'hFFFF
- first_err_idx  out  16  beat_cnt value of first mismatch (0-based)
- exp_overflow  out  1  sticky: exp_wr seen while FIFO full
- test_done  out  1  run finished (level, held in DONE)
- test_pass  out  1  valid when test_done: err_cnt==0 and !exp_overflow

## Operation
- States: IDLE, CHECK, FLUSH, DONE. Reset → IDLE.
- IDLE/DONE + chk_start → CHECK.
  - Clears beat_cnt, err_cnt, first_err_idx, exp_overflow, the accept counter, test_done and test_pass.
  - Does not flush the expected FIFO.
- CHECK + chk_start: ignored.
- CHECK:
  - rx_ready = !exp_empty && !chk_stop && !(chk_cnt!=0 && acc_cnt==chk_cnt).
  - Accept = rx_valid && rx_ready. It pops the FIFO head and increments acc_cnt (8-bit).
- CHECK → FLUSH on either condition:
  - chk_stop, or
  - the accept that makes acc_cnt==chk_cnt (chk_cnt≠0).
- FLUSH: one cycle, retires the in-flight compare, → DONE.
- DONE: test_done=1, test_pass registered. Holds until chk_start or rst.
- IDLE/FLUSH/DONE: rx_ready=0.
- Compare: full DATA_WIDTH equality of rx_data vs FIFO head, registered 1 stage.
  - On a mismatch, err_cnt increments (saturating).
  - If err_cnt was 0, first_err_idx ← beat_cnt.
  - beat_cnt increments on every compare and wraps at 16 bits.
- Expected FIFO:
  - Push when exp_wr && !full. A push while full is dropped and sets exp_overflow.
  - Simultaneous push and pop when full: the push is still dropped, because full is evaluated pre-pop.
  - Push is accepted in any state.
- chkr_fifo_full = registered (count==EXP_DEPTH).
- rx_valid while rx_ready=0: no effect. Data need not be held stable by this block.

## Timing
- Reset values: rx_ready 0, chkr_fifo_full 0, beat_cnt 0, err_cnt 0, first_err_idx 0, exp_overflow 0, test_done 0, test_pass 0. Expected FIFO empty.
- rst mid-run: next cycle is IDLE with all of the above cleared and the FIFO emptied.
- Expected FIFO:
  - Push on edge N → head visible and rx_ready can be 1 in cycle N+1 (CHECK).
  - Pop on accept edge → next head visible in the following cycle; back-to-back accepts are allowed.
- Accept on edge N → beat_cnt/err_cnt update on edge N+1.
- Last accept on edge N (chk_cnt run) → FLUSH during N+1 → test_done=1 from edge N+2.
- chk_stop sampled high in CHECK at edge N:
  - rx_ready is 0 in that cycle (combinational), so there is no accept at edge N.
  - test_done=1 from edge N+2.
- chkr_fifo_full lags count by one cycle. The generator may push once while the flag is stale; that push is dropped and flagged.

## Test plan
- Fixed pattern, chk_cnt=8: 8 exp words 40'h1111112222 replicated; 8 matching beats, rx_valid always 1 → 8 accepts, beat_cnt=8, err_cnt=0, test_done=1 with test_pass=1 two cycles after last accept.
- Single corruption: 8-beat increment pattern, beat 3 bit 0 flipped → err_cnt=1, first_err_idx=3, test_pass=0.
- Back-pressure: 4 exp words loaded, 6 beats offered → rx_ready drops after 4th accept; 2 more exp words → remaining 2 accepted, beat_cnt=6.
- Overflow: EXP_DEPTH+1 pushes with no run active → chkr_fifo_full=1, exp_overflow=1, and a subsequent 16-beat run has test_pass=0 even with all-matching data.
- Continuous mode: chk_cnt=0, 20 beats, chk_stop pulse → no accept in stop cycle, test_done two edges after stop, beat_cnt=20.
- Reset mid-run: rst after 5 of 10 beats → all outputs at reset values next cycle, rx_ready=0, FIFO empty (new run needs fresh exp words).

Source files
------------

// File: rtl/axi_mm_patchkr_if.sv
// Generator-to-checker link: expected-word push channel plus the received valid/ready beat stream.
// Latency: none, wires only. Backpressure: chkr_fifo_full throttles pushes, rx_ready throttles beats.
interface axi_mm_patchkr_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] exp_din;
   logic                  exp_wr;
   logic                  chkr_fifo_full;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;

   modport master (
      output exp_din, exp_wr, rx_data, rx_valid,
      input  chkr_fifo_full, rx_ready
   );

   modport slave (
      input  exp_din, exp_wr, rx_data, rx_valid,
      output chkr_fifo_full, rx_ready
   );
endinterface

// File: rtl/axi_mm_patchkr_top.sv
// Receive-side pattern checker: compares accepted beats with buffered expected words and reports a verdict.
// Latency: 1-cycle compare, test_done 2 edges after the last accept. Backpressure: rx_ready needs an expected word.

module axi_mm_patchkr_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;

   // full is judged on the pre-pop count, so a push against a full FIFO is dropped even when popping
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module axi_mm_patchkr_top #(
   parameter int DATA_WIDTH = 128,
   parameter int EXP_DEPTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_mm_patchkr_if.slave      bus,
   input  logic                 chk_start,
   input  logic                 chk_stop,
   input  logic [7:0]           chk_cnt,
   output logic [15:0]          beat_cnt,
   output logic [15:0]          err_cnt,
   output logic [15:0]          first_err_idx,
   output logic                 exp_overflow,
   output logic                 test_done,
   output logic                 test_pass
);
   typedef enum logic [1:0] {IDLE, CHECK, FLUSH, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  rx_ready_c;
   logic                  accept;
   logic                  cnt_hit;
   logic                  last_acc;
   logic                  start_ok;
   logic                  ovf_evt;
   logic [7:0]            acc_cnt;
   logic                  cmp_vld;
   logic                  cmp_mis;
   logic                  full_q;

   axi_mm_patchkr_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (EXP_DEPTH)
   ) u_exp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.exp_wr),
      .din   (bus.exp_din),
      .pop   (accept),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign cnt_hit  = (chk_cnt != 8'd0) && (acc_cnt == chk_cnt);
   assign accept   = bus.rx_valid && rx_ready_c;
   assign last_acc = accept && (chk_cnt != 8'd0) && ((acc_cnt + 8'd1) == chk_cnt);
   assign start_ok = chk_start && ((state == IDLE) || (state == DONE));
   assign ovf_evt  = bus.exp_wr && fifo_full;

   assign bus.rx_ready       = rx_ready_c;
   assign bus.chkr_fifo_full = full_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (chk_start) state_nxt = CHECK;
         CHECK:   if (chk_stop || last_acc) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    if (chk_start) state_nxt = CHECK;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready_c = 1'b0;
      if (state == CHECK) begin
         rx_ready_c = !fifo_empty && !chk_stop && !cnt_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt       <= '0;
         cmp_vld       <= 1'b0;
         cmp_mis       <= 1'b0;
         beat_cnt      <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         exp_overflow  <= 1'b0;
         full_q        <= 1'b0;
         test_done     <= 1'b0;
         test_pass     <= 1'b0;
      end else begin
         full_q       <= fifo_full;
         cmp_vld      <= accept;
         cmp_mis      <= (bus.rx_data != fifo_dout);
         exp_overflow <= (start_ok ? 1'b0 : exp_overflow) | ovf_evt;

         if (start_ok) begin
            acc_cnt       <= '0;
            beat_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            test_done     <= 1'b0;
            test_pass     <= 1'b0;
         end else begin
            if (accept) begin
               acc_cnt <= acc_cnt + 8'd1;
            end
            if (cmp_vld) begin
               beat_cnt <= beat_cnt + 16'd1;
               if (cmp_mis) begin
                  if (err_cnt == 16'd0) begin
                     first_err_idx <= beat_cnt;
                  end
                  if (err_cnt != 16'hFFFF) begin
                     err_cnt <= err_cnt + 16'd1;
                  end
               end
            end
            // verdict is registered off DONE so it sees the counts after the flushed compare
            if (state == DONE) begin
               test_done <= 1'b1;
               test_pass <= (err_cnt == 16'd0) && !exp_overflow;
            end
         end
      end
   end
endmodule

// File: tb/tb_axi_mm_patchkr_top.sv
// Scoreboard bench for axi_mm_patchkr_top: expected words are queued on push and retired on each accept.
module tb_axi_mm_patchkr_top;
   localparam int DW    = 128;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          chk_start;
   logic          chk_stop;
   logic [7:0]    chk_cnt;
   logic [15:0]   beat_cnt;
   logic [15:0]   err_cnt;
   logic [15:0]   first_err_idx;
   logic          exp_overflow;
   logic          test_done;
   logic          test_pass;

   axi_mm_patchkr_if #(.DATA_WIDTH(DW)) bus ();

   axi_mm_patchkr_top #(
      .DATA_WIDTH (DW),
      .EXP_DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .chk_start     (chk_start),
      .chk_stop      (chk_stop),
      .chk_cnt       (chk_cnt),
      .beat_cnt      (beat_cnt),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx),
      .exp_overflow  (exp_overflow),
      .test_done     (test_done),
      .test_pass     (test_pass)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mq [$];
   logic [DW-1:0] rx_pat [0:31];
   int            n_chk  = 0;
   int            n_pass = 0;
   int            m_beat;
   int            m_err;
   int            m_first;
   bit            m_ovf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [DW-1:0] w);
      bus.exp_din = w;
      bus.exp_wr  = 1'b1;
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1'b1;
      tick();
      bus.exp_wr = 1'b0;
   endtask

   task automatic start_run(input logic [7:0] n);
      chk_cnt   = n;
      chk_start = 1'b1;
      m_beat    = 0;
      m_err     = 0;
      m_first   = 0;
      m_ovf     = 1'b0;
      tick();
      chk_start = 1'b0;
   endtask

   // offers rx_pat[first..first+n-1]; each accept retires the scoreboard head into the model counts
   task automatic stream(input int first, input int n, input int budget, output int acc);
      logic [DW-1:0] e;
      acc = 0;
      bus.rx_valid = 1'b1;
      for (int c = 0; c < budget && acc < n; c++) begin
         bus.rx_data = rx_pat[first + acc];
         #1;
         if (bus.rx_ready) begin
            e = (mq.size() > 0) ? mq.pop_front() : ~bus.rx_data;
            if (e !== bus.rx_data) begin
               if (m_err == 0) m_first = m_beat;
               m_err++;
            end
            m_beat = (m_beat + 1) & 16'hFFFF;
            acc++;
         end
         tick();
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_chk++; if (bus.rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); else n_pass++;
      n_chk++; if (bus.chkr_fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.chkr_fifo_full); else n_pass++;
      n_chk++; if (beat_cnt !== 16'd0) $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); else n_pass++;
      n_chk++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
      n_chk++; if (first_err_idx !== 16'd0) $display("FAIL reset_first_err got %0d want 0", first_err_idx); else n_pass++;
      n_chk++; if (exp_overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", exp_overflow); else n_pass++;
      n_chk++; if (test_done !== 1'b0) $display("FAIL reset_done got %b want 0", test_done); else n_pass++;
      n_chk++; if (test_pass !== 1'b0) $display("FAIL reset_pass got %b want 0", test_pass); else n_pass++;
   endtask

   task automatic test_fixed();
      logic [159:0] t;
      int acc;
      t = {4{40'h1111112222}};
      for (int i = 0; i < 8; i++) rx_pat[i] = t[DW-1:0];
      start_run(8'd8);
      for (int i = 0; i < 8; i++) push_exp(rx_pat[i]);
      stream(0, 8, 20, acc);
      n_chk++; if (acc !== 8) $display("FAIL fixed_accepts got %0d want 8", acc); else n_pass++;
      n_chk++; if (test_done !== 1'b0) $display("FAIL fixed_done_early got %b want 0", test_done); else n_pass++;
      tick();
      n_chk++; if (test_done !== 1'b0) $display("FAIL fixed_done_edge1 got %b want 0", test_done); else n_pass++;
      tick();
      n_chk++; if (test_done !== 1'b1) $display("FAIL fixed_done_edge2 got %b want 1", test_done); else n_pass++;
      n_chk++; if (test_pass !== 1'b1) $display("FAIL fixed_pass got %b want 1", test_pass); else n_pass++;
      n_chk++; if (beat_cnt !== 16'd8) $display("FAIL fixed_beat_cnt got %0d want 8", beat_cnt); else n_pass++;
      n_chk++; if (err_cnt !== 16'd0) $display("FAIL fixed_err_cnt got %0d want 0", err_cnt); else n_pass++;
      bus.rx_valid = 1'b1;
      #1;
      n_chk++; if (bus.rx_ready !== 1'b0) $display("FAIL fixed_ready_in_done got %b want 0", bus.rx_ready); else n_pass++;
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_corrupt();
      int acc;
      for (int i = 0; i < 8; i++) rx_pat[i] = DW'(i + 1);
      for (int i = 0; i < 8; i++) push_exp(rx_pat[i]);
      rx_pat[3] = rx_pat[3] ^ DW'(1);
      start_run(8'd8);
      n_chk++; if (test_done !== 1'b0) $display("FAIL corrupt_start_clears_done got %b want 0", test_done); else n_pass++;
      n_chk++; if (beat_cnt !== 16'd0) $display("FAIL corrupt_start_clears_beat got %0d want 0", beat_cnt); else n_pass++;
      stream(0, 8, 20, acc);
      tick();
      tick();
      n_chk++; if (err_cnt !== 16'(m_err) || err_cnt !== 16'd1) $display("FAIL corrupt_err_cnt got %0d want 1", err_cnt); else n_pass++;
      n_chk++; if (first_err_idx !== 16'(m_first) || first_err_idx !== 16'd3) $display("FAIL corrupt_first_err got %0d want 3", first_err_idx); else n_pass++;
      n_chk++; if (test_done !== 1'b1) $display("FAIL corrupt_done got %b want 1", test_done); else n_pass++;
      n_chk++; if (test_pass !== 1'b0) $display("FAIL corrupt_pass got %b want 0", test_pass); else n_pass++;
   endtask

   task automatic test_backpressure();
      int acc;
      int acc2;
      for (int i = 0; i < 6; i++) rx_pat[i] = {4{32'hA5000000 + 32'(i)}};
      start_run(8'd6);
      for (int i = 0; i < 4; i++) push_exp(rx_pat[i]);
      stream(0, 6, 10, acc);
      n_chk++; if (acc !== 4) $display("FAIL bp_first_accepts got %0d want 4", acc); else n_pass++;
      n_chk++; if (bus.rx_ready !== 1'b0) $display("FAIL bp_ready_drop got %b want 0", bus.rx_ready); else n_pass++;
      for (int i = 4; i < 6; i++) push_exp(rx_pat[i]);
      stream(4, 2, 10, acc2);
      n_chk++; if (acc2 !== 2) $display("FAIL bp_second_accepts got %0d want 2", acc2); else n_pass++;
      tick();
      tick();
      n_chk++; if (beat_cnt !== 16'd6) $display("FAIL bp_beat_cnt got %0d want 6", beat_cnt); else n_pass++;
      n_chk++; if (test_done !== 1'b1 || test_pass !== 1'b1) $display("FAIL bp_verdict got done=%b pass=%b want 1/1", test_done, test_pass); else n_pass++;
   endtask

   task automatic test_overflow();
      int acc;
      for (int i = 0; i < 17; i++) rx_pat[i] = {DW/32{32'h0F0F0000 + 32'(i * 3)}};
      for (int i = 0; i < 17; i++) push_exp(rx_pat[i]);
      n_chk++; if (bus.chkr_fifo_full !== 1'b1) $display("FAIL ovf_full got %b want 1", bus.chkr_fifo_full); else n_pass++;
      n_chk++; if (exp_overflow !== m_ovf || exp_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", exp_overflow); else n_pass++;
      start_run(8'd16);
      n_chk++; if (exp_overflow !== 1'b0) $display("FAIL ovf_start_clears got %b want 0", exp_overflow); else n_pass++;
      push_exp(rx_pat[16]);
      n_chk++; if (exp_overflow !== 1'b1) $display("FAIL ovf_in_run got %b want 1", exp_overflow); else n_pass++;
      stream(0, 16, 24, acc);
      n_chk++; if (acc !== 16) $display("FAIL ovf_accepts got %0d want 16", acc); else n_pass++;
      tick();
      tick();
      n_chk++; if (err_cnt !== 16'd0 || beat_cnt !== 16'd16) $display("FAIL ovf_counts got err=%0d beat=%0d want 0/16", err_cnt, beat_cnt); else n_pass++;
      n_chk++; if (test_done !== 1'b1) $display("FAIL ovf_done got %b want 1", test_done); else n_pass++;
      n_chk++; if (test_pass !== (m_err == 0 && !m_ovf) || test_pass !== 1'b0) $display("FAIL ovf_pass got %b want 0", test_pass); else n_pass++;
      n_chk++; if (bus.chkr_fifo_full !== 1'b0) $display("FAIL ovf_full_after got %b want 0", bus.chkr_fifo_full); else n_pass++;
   endtask

   task automatic test_continuous();
      int acc;
      int acc2;
      for (int i = 0; i < 21; i++) rx_pat[i] = DW'(i * 7 + 5) << 64;
      start_run(8'd0);
      for (int i = 0; i < 10; i++) push_exp(rx_pat[i]);
      stream(0, 10, 20, acc);
      for (int i = 10; i < 20; i++) push_exp(rx_pat[i]);
      stream(10, 10, 20, acc2);
      n_chk++; if (acc + acc2 !== 20) $display("FAIL cont_accepts got %0d want 20", acc + acc2); else n_pass++;
      push_exp(rx_pat[20]);
      bus.rx_valid = 1'b1;
      bus.rx_data  = rx_pat[20];
      chk_stop     = 1'b1;
      #1;
      n_chk++; if (bus.rx_ready !== 1'b0) $display("FAIL cont_ready_in_stop got %b want 0", bus.rx_ready); else n_pass++;
      tick();
      chk_stop     = 1'b0;
      bus.rx_valid = 1'b0;
      n_chk++; if (test_done !== 1'b0) $display("FAIL cont_done_edge0 got %b want 0", test_done); else n_pass++;
      tick();
      n_chk++; if (test_done !== 1'b0) $display("FAIL cont_done_edge1 got %b want 0", test_done); else n_pass++;
      tick();
      n_chk++; if (test_done !== 1'b1) $display("FAIL cont_done_edge2 got %b want 1", test_done); else n_pass++;
      n_chk++; if (beat_cnt !== 16'd20) $display("FAIL cont_beat_cnt got %0d want 20", beat_cnt); else n_pass++;
      n_chk++; if (test_pass !== 1'b1) $display("FAIL cont_pass got %b want 1", test_pass); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      int acc;
      logic [52:0] outs;
      for (int i = 0; i < 10; i++) rx_pat[i] = ~DW'(i * 11);
      start_run(8'd10);
      for (int i = 0; i < 10; i++) push_exp(rx_pat[i]);
      stream(0, 5, 10, acc);
      n_chk++; if (acc !== 5) $display("FAIL mid_accepts got %0d want 5", acc); else n_pass++;
      rst = 1'b1;
      bus.rx_valid = 1'b1;
      tick();
      mq.delete();
      outs = {bus.rx_ready, bus.chkr_fifo_full, beat_cnt, err_cnt, first_err_idx, exp_overflow, test_done, test_pass};
      n_chk++; if (outs !== '0) $display("FAIL mid_reset_outputs got %h want 0", outs); else n_pass++;
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      tick();
      start_run(8'd2);
      bus.rx_valid = 1'b1;
      #1;
      n_chk++; if (bus.rx_ready !== 1'b0) $display("FAIL mid_fifo_empty_ready got %b want 0", bus.rx_ready); else n_pass++;
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 2; i++) rx_pat[i] = DW'(32'hBEEF0000 + 32'(i));
      for (int i = 0; i < 2; i++) push_exp(rx_pat[i]);
      stream(0, 2, 6, acc);
      tick();
      tick();
      n_chk++; if (beat_cnt !== 16'd2) $display("FAIL mid_new_run_beat got %0d want 2", beat_cnt); else n_pass++;
      n_chk++; if (test_done !== 1'b1 || test_pass !== 1'b1) $display("FAIL mid_new_run_verdict got done=%b pass=%b want 1/1", test_done, test_pass); else n_pass++;
   endtask

   initial begin
      rst          = 1'b1;
      chk_start    = 1'b0;
      chk_stop     = 1'b0;
      chk_cnt      = 8'd0;
      bus.exp_din  = '0;
      bus.exp_wr   = 1'b0;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      m_beat       = 0;
      m_err        = 0;
      m_first      = 0;
      m_ovf        = 1'b0;
      test_reset();
      test_fixed();
      test_corrupt();
      test_backpressure();
      test_overflow();
      test_continuous();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
